// File: rtl/cdiv_rr_sched_if.sv
// Bus bundle for the shared complex-divider scheduler:
// requester side, divider side and response side.
interface cdiv_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 24
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a_re;
  logic [NREQ*W-1:0] req_a_im;
  logic [NREQ*W-1:0] req_b_re;
  logic [NREQ*W-1:0] req_b_im;
  logic [NREQ*5-1:0] req_mbit1;
  logic [NREQ*5-1:0] req_mbit2;

  logic [W-1:0] div_a_re;
  logic [W-1:0] div_a_im;
  logic [W-1:0] div_b_re;
  logic [W-1:0] div_b_im;
  logic [4:0]   div_mbit1;
  logic [4:0]   div_mbit2;
  logic [W-1:0] div_res_re;
  logic [W-1:0] div_res_im;
  logic [4:0]   div_res_mbit;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [W-1:0]  rsp_re;
  logic [W-1:0]  rsp_im;
  logic [4:0]    rsp_mbit;
  logic          rsp_err;

  modport slave (
    input  req_valid, req_a_re, req_a_im,
    input  req_b_re, req_b_im,
    input  req_mbit1, req_mbit2,
    input  div_res_re, div_res_im, div_res_mbit,
    input  rsp_ready,
    output req_ready,
    output div_a_re, div_a_im, div_b_re, div_b_im,
    output div_mbit1, div_mbit2,
    output rsp_valid, rsp_id, rsp_re, rsp_im,
    output rsp_mbit, rsp_err
  );

  modport master (
    output req_valid, req_a_re, req_a_im,
    output req_b_re, req_b_im,
    output req_mbit1, req_mbit2,
    output div_res_re, div_res_im, div_res_mbit,
    output rsp_ready,
    input  req_ready,
    input  div_a_re, div_a_im, div_b_re, div_b_im,
    input  div_mbit1, div_mbit2,
    input  rsp_valid, rsp_id, rsp_re, rsp_im,
    input  rsp_mbit, rsp_err
  );
endinterface

// File: rtl/cdiv_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency EFP24
// complex divider; zero denominators answered locally.
module cdiv_rr_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 24,
  parameter int DIV_LAT = 7,
  parameter int GAP     = 1
) (
  input logic             clk,
  input logic             rst_n,
  cdiv_rr_sched_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DIV_LAT + GAP + 1);

  typedef enum logic [1:0] {
    IDLE, HOLD, RESP, DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] scan;
  logic [IW-1:0] win;
  logic [NREQ-1:0] grant;
  logic          hit;
  logic          accept;

  logic [W-1:0] a_re, a_im, b_re, b_im;
  logic [4:0]   m1, m2, mmax;
  logic         bzero;

  // rotating priority search starting one past last_grant
  always_comb begin
    grant = '0;
    win   = '0;
    hit   = 1'b0;
    scan  = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      scan = (scan == IW'(NREQ - 1)) ? '0 : scan + 1'b1;
      if (!hit && bus.req_valid[scan]) begin
        hit = 1'b1;
        win = scan;
      end
    end
    if (hit) grant[win] = 1'b1;
  end

  assign bus.req_ready =
    (state == IDLE && rst_n) ? grant : '0;
  assign accept = |bus.req_ready;

  assign a_re  = bus.req_a_re[win*W +: W];
  assign a_im  = bus.req_a_im[win*W +: W];
  assign b_re  = bus.req_b_re[win*W +: W];
  assign b_im  = bus.req_b_im[win*W +: W];
  assign m1    = bus.req_mbit1[win*5 +: 5];
  assign m2    = bus.req_mbit2[win*5 +: 5];
  assign mmax  = (m1 > m2) ? m1 : m2;
  assign bzero = ~|{b_re, b_im};

  // control FSM with registered divider and response buses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= IW'(NREQ - 1);
      bus.div_a_re  <= '0;
      bus.div_a_im  <= '0;
      bus.div_b_re  <= '0;
      bus.div_b_im  <= '0;
      bus.div_mbit1 <= '0;
      bus.div_mbit2 <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_re    <= '0;
      bus.rsp_im    <= '0;
      bus.rsp_mbit  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= win;
            bus.rsp_id <= win;
            if (bzero) begin
              bus.rsp_re    <= '0;
              bus.rsp_im    <= '0;
              bus.rsp_mbit  <= mmax;
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.div_a_re  <= a_re;
              bus.div_a_im  <= a_im;
              bus.div_b_re  <= b_re;
              bus.div_b_im  <= b_im;
              bus.div_mbit1 <= m1;
              bus.div_mbit2 <= m2;
              cnt           <= CW'(DIV_LAT - 1);
              state         <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus.rsp_re    <= bus.div_res_re;
            bus.rsp_im    <= bus.div_res_im;
            bus.rsp_mbit  <= bus.div_res_mbit;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.div_a_re  <= '0;
            bus.div_a_im  <= '0;
            bus.div_b_re  <= '0;
            bus.div_b_im  <= '0;
            bus.div_mbit1 <= '0;
            bus.div_mbit2 <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (GAP == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= CW'(GAP - 1);
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          bus.div_a_re  <= '0;
          bus.div_a_im  <= '0;
          bus.div_b_re  <= '0;
          bus.div_b_im  <= '0;
          bus.div_mbit1 <= '0;
          bus.div_mbit2 <= '0;
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdiv_rr_sched.sv
// Directed + randomized bench for cdiv_rr_sched with a
// stand-in fixed-latency divider and a request-level model.
module tb_cdiv_rr_sched;
  localparam int NREQ    = 4;
  localparam int W       = 24;
  localparam int DIV_LAT = 7;
  localparam int GAP     = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdiv_rr_sched_if #(.NREQ(NREQ), .W(W)) bus();

  cdiv_rr_sched #(
    .NREQ(NREQ), .W(W),
    .DIV_LAT(DIV_LAT), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [4:0]   mb;
  } dres_t;

  // stand-in divider: deterministic mix of its operands
  function automatic dres_t mix(
    input logic [W-1:0] ar, ai, br, bi,
    input logic [4:0] t1, t2);
    dres_t r;
    r.re = ar ^ {br[11:0], br[23:12]} ^ 24'h5a5a5a;
    r.im = ai + bi + (br >> 3);
    r.mb = t1 + t2 + 5'd1;
    return r;
  endfunction

  dres_t pipe [DIV_LAT-1];

  // DIV_LAT-1 stages: result in cycle DIV_LAT reflects cycle-1 operands
  always @(posedge clk) begin
    pipe[0] <= mix(bus.div_a_re, bus.div_a_im,
                   bus.div_b_re, bus.div_b_im,
                   bus.div_mbit1, bus.div_mbit2);
    for (int i = 1; i < DIV_LAT - 1; i++)
      pipe[i] <= pipe[i-1];
  end

  assign bus.div_res_re   = pipe[DIV_LAT-2].re;
  assign bus.div_res_im   = pipe[DIV_LAT-2].im;
  assign bus.div_res_mbit = pipe[DIV_LAT-2].mb;

  int vectors     = 0;
  int miscompares = 0;
  int last_g      = NREQ - 1;

  logic [W-1:0]    ar [NREQ];
  logic [W-1:0]    ai [NREQ];
  logic [W-1:0]    br [NREQ];
  logic [W-1:0]    bi [NREQ];
  logic [4:0]      m1 [NREQ];
  logic [4:0]      m2 [NREQ];
  logic [NREQ-1:0] vmask;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req_valid = vmask;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a_re[i*W +: W]  = ar[i];
      bus.req_a_im[i*W +: W]  = ai[i];
      bus.req_b_re[i*W +: W]  = br[i];
      bus.req_b_im[i*W +: W]  = bi[i];
      bus.req_mbit1[i*5 +: 5] = m1[i];
      bus.req_mbit2[i*5 +: 5] = m2[i];
    end
  endtask

  task automatic rnd(input int i, input bit zero);
    ar[i] = W'($urandom);
    ai[i] = W'($urandom);
    if (zero) begin
      br[i] = '0;
      bi[i] = '0;
    end else begin
      br[i] = W'($urandom);
      bi[i] = W'($urandom);
      if (br[i] == '0 && bi[i] == '0) br[i] = 24'h3e0000;
    end
    m1[i] = 5'($urandom_range(0, 17));
    m2[i] = 5'($urandom_range(0, 17));
  endtask

  // requester nearest after `last` in circular order wins
  function automatic int pick(input int last,
                              input logic [NREQ-1:0] m);
    int best;
    int bestd;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (m[i] && ((i - last - 1 + 2*NREQ) % NREQ) < bestd) begin
        bestd = (i - last - 1 + 2*NREQ) % NREQ;
        best  = i;
      end
    return best;
  endfunction

  function automatic logic [31:0] div_or();
    return 32'(|{bus.div_a_re, bus.div_a_im,
                 bus.div_b_re, bus.div_b_im,
                 bus.div_mbit1, bus.div_mbit2});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    last_g = NREQ - 1;
  endtask

  // entered in a potential acceptance cycle with inputs settled;
  // returns just after the edge that opens the next such cycle
  task automatic do_op(input int bp, input bit drop,
                       input bit reroll);
    int w;
    bit z;
    logic [W-1:0] s_ar, s_ai, s_br, s_bi;
    logic [4:0]   s_m1, s_m2;
    dres_t e;
    w = pick(last_g, vmask);
    chk("grant", 32'(bus.req_ready),
        (w < 0) ? 32'd0 : 32'(1 << w));
    if (w < 0) begin
      step();
      return;
    end
    s_ar = ar[w]; s_ai = ai[w];
    s_br = br[w]; s_bi = bi[w];
    s_m1 = m1[w]; s_m2 = m2[w];
    z = (s_br == '0 && s_bi == '0);
    last_g = w;
    step();
    if (drop) vmask[w] = 1'b0;
    if (reroll) rnd(w, 1'b0);
    drive();
    #1;
    if (!z) begin
      for (int c = 1; c <= DIV_LAT; c++) begin
        chk("div_a_re", 32'(bus.div_a_re), 32'(s_ar));
        chk("div_a_im", 32'(bus.div_a_im), 32'(s_ai));
        chk("div_b_re", 32'(bus.div_b_re), 32'(s_br));
        chk("div_b_im", 32'(bus.div_b_im), 32'(s_bi));
        chk("div_mbit1", 32'(bus.div_mbit1), 32'(s_m1));
        chk("div_mbit2", 32'(bus.div_mbit2), 32'(s_m2));
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        step();
      end
      e = mix(s_ar, s_ai, s_br, s_bi, s_m1, s_m2);
    end else begin
      e.re = '0;
      e.im = '0;
      e.mb = (s_m1 > s_m2) ? s_m1 : s_m2;
    end
    for (int c = 0; c <= bp; c++) begin
      bus.rsp_ready = (c == bp);
      #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(w));
      chk("rsp_re", 32'(bus.rsp_re), 32'(e.re));
      chk("rsp_im", 32'(bus.rsp_im), 32'(e.im));
      chk("rsp_mbit", 32'(bus.rsp_mbit), 32'(e.mb));
      chk("rsp_err", 32'(bus.rsp_err), 32'(z));
      chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
      if (z) chk("zero_div_bus", div_or(), 32'd0);
      step();
    end
    for (int g = 0; g < GAP; g++) begin
      #1;
      chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("drain_div_bus", div_or(), 32'd0);
      chk("drain_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) rnd(i, 1'b0);
    vmask = '1;
    bus.rsp_ready = 1'b1;
    drive();

    // reset state
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_re", 32'(bus.rsp_re), 32'd0);
    chk("rst_rsp_im", 32'(bus.rsp_im), 32'd0);
    chk("rst_rsp_mbit", 32'(bus.rsp_mbit), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_div_bus", div_or(), 32'd0);
    rst_n  = 1'b1;
    last_g = NREQ - 1;

    // single request from requester 2
    ar[2] = 24'h400000; ai[2] = '0;
    br[2] = 24'h3e0000; bi[2] = '0;
    m1[2] = 5'd8;       m2[2] = 5'd8;
    vmask = 4'b0100;
    drive();
    #1;
    do_op(0, 1'b1, 1'b0);

    // divide by zero from requester 1
    rnd(1, 1'b1);
    m1[1] = 5'd5;
    m2[1] = 5'd9;
    vmask = 4'b0010;
    drive();
    #1;
    do_op(0, 1'b1, 1'b0);

    // contention after reset: 0,1,2,3,0 every 10 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) rnd(i, 1'b0);
    vmask = '1;
    drive();
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", 32'(pick(last_g, vmask)), 32'(k % NREQ));
      do_op(0, 1'b0, 1'b1);
      #1;
    end

    // back-pressure for 20 cycles, then next grant 2 after handshake
    do_op(20, 1'b0, 1'b1);
    #1;
    do_op(0, 1'b0, 1'b1);

    // reset in cycle 4 of a hold, then the same request again
    do_reset();
    vmask = '1;
    drive();
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'd1);
    for (int c = 0; c < 4; c++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_div_bus", div_or(), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    step();
    rst_n  = 1'b1;
    last_g = NREQ - 1;
    #1;
    do_op(0, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        vmask[i] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0)
          rnd(i, ($urandom_range(0, 4) == 0));
      end
      drive();
      #1;
      do_op(int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdiv_rr_sched.md
# cdiv_rr_sched

Round-robin scheduler that shares one EFP24 complex divider (1 sign / 6 exponent / 17 mantissa bits, bias 31, fixed 7-cycle latency, no start/done strobes) among NREQ requesters. It accepts one division at a time, holds the operands stable on the divider bus for the full latency window, and captures the result. It returns the result to the granted requester with a valid/ready handshake. Divide-by-zero requests are answered locally without using the divider.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 24: EFP operand width
- DIV_LAT, 7: divider latency in cycles; operands are held this many cycles
- GAP, 1: cycles of all-zero operands driven between operations
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  one-hot grant; the request is accepted when req_valid[i]&&req_ready[i]
- req_a_re, req_a_im, req_b_re, req_b_im  in  NREQ*W each  numerator and denominator, requester i at bits [i*W +: W]
- req_mbit1, req_mbit2  in  NREQ*5 each  mantissa-width tags
- div_a_re, div_a_im, div_b_re, div_b_im  out  W each  registered divider operands
- div_mbit1, div_mbit2  out  5 each  registered tags to the divider
- div_res_re, div_res_im  in  W each  divider result
- div_res_mbit  in  5  divider result tag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  $clog2(NREQ)  requester index
- rsp_re, rsp_im  out  W each  quotient
- rsp_mbit  out  5  result tag
- rsp_err  out  1  denominator was zero

## Operation
- States and transitions:
  - IDLE -> HOLD on an accepted request with a nonzero denominator.
  - IDLE -> RESP on an accepted request with b_re==0 && b_im==0.
  - HOLD -> RESP when the hold counter expires.
  - RESP -> DRAIN on the rsp handshake.
  - DRAIN -> IDLE after GAP cycles.
- Arbitration:
  - Active only in IDLE; req_ready is combinational and zero outside IDLE.
  - Priority starts at last_grant+1 and wraps modulo NREQ.
  - last_grant updates on acceptance only.
  - Reset value of last_grant is NREQ-1, so requester 0 has first priority.
- Acceptance:
  - Operands and tags of the winner are registered onto the div_* buses, and rsp_id is registered.
  - The requester may change or drop its inputs afterwards.
- HOLD:
  - div_* stay constant for exactly DIV_LAT cycles; the counter loads DIV_LAT-1 and counts down to 0.
  - On the edge leaving HOLD, div_res_re/im/mbit are captured into rsp_re/im/mbit and rsp_err=0.
- Zero-denominator path:
  - The divider bus is not loaded and keeps zeros.
  - rsp_re = rsp_im = 0, rsp_err = 1, rsp_mbit = max(mbit1, mbit2) of the request.
- RESP:
  - rsp_valid=1 and all rsp_* are stable until rsp_ready.
  - A handshake in the first RESP cycle is legal.
- DRAIN: all div_* are driven to 0 for GAP cycles so the divider returns to its idle path before the next operand set.
- Requests whose req_valid drops before acceptance are simply not served. There is no obligation to hold req_valid.

## Timing
- Acceptance in cycle 0:
  - div_* are valid in cycles 1..DIV_LAT.
  - The result is captured at the end of cycle DIV_LAT.
  - rsp_valid is high from cycle DIV_LAT+1 (cycle 8 with defaults).
- Zero-denominator acceptance in cycle 0: rsp_valid is high in cycle 1.
- rsp handshake in cycle k:
  - rsp_valid is low in cycle k+1.
  - DRAIN covers k+1..k+GAP.
  - The earliest next acceptance is cycle k+GAP+1.
- Maximum throughput is one division per DIV_LAT+GAP+2 cycles (10 with defaults).
- Reset values: all outputs 0, state IDLE, counters 0, last_grant NREQ-1.
- Asserting rst_n low mid-operation:
  - The in-flight operation and any pending response are discarded.
  - div_* go to 0 immediately.
  - No response for that request is ever produced.

## Test plan
- Single request: requester 2 in cycle 0 with a=(0x400000, 0), b=(0x3E0000, 0), mbit 8/8 -> req_ready=0b0100 in cycle 0; div_* constant in cycles 1-7; rsp_valid in cycle 8 with rsp_id=2, rsp_re/im equal to the divider model, rsp_err=0.
- Contention: all 4 req_valid held high after reset -> grants in order 0,1,2,3,0 with spacing of 10 cycles when rsp_ready is tied high.
- Divide by zero: b=(0,0), mbit1=5, mbit2=9 -> rsp_valid in cycle 1, rsp_err=1, rsp_re=rsp_im=0, rsp_mbit=9; div_* remain 0 throughout.
- Back-pressure: hold rsp_ready low for 20 cycles after rsp_valid -> rsp_* stable, req_ready stays 0; release -> DRAIN then the next grant 2 cycles after the handshake.
- Reset mid-HOLD: drop rst_n in cycle 4 -> all outputs 0 at once; after release the same request is re-granted to requester 0 first and completes normally.
- Drain check: back-to-back requests -> div_* all zero during the DRAIN cycle between operations.
